axis_stereo_source_arbiter: RTL
===============================

// Module: axis_stereo_source_arbiter
// PURPOSE
//  Two-source AXIS arbiter in front of the I2S2 TX stream: forwards stereo frames (left beat last=0,
//  right beat last=1) from one of two producers (line-in path, tone/playback path) to the TX controller.
//  Grant changes only on frame boundaries. Frames are re-paired and errors counted. Mute substitutes zero samples.
// PARAMETERS
//  DATA_WIDTH    24  sample width, all data ports
//  DRAIN_UNSEL   1   1: non-granted source held ready=1, beats discarded; 0: held ready=0
//  ERR_WIDTH     8   width of saturating alignment-error counter
// PORTS
//  axis_clk       in   1           sole clock
//  reset          in   1           asynchronous, active-high reset
//  sel            in   1           requested source (0=s0, 1=s1), asynchronous switch input
//  mute           in   1           asynchronous switch; 1 = forward zero data, keep framing
//  s0_axis_data   in   DATA_WIDTH  source 0 sample
//  s0_axis_valid  in   1
//  s0_axis_ready  out  1
//  s0_axis_last   in   1           1 = right channel
//  s1_axis_*      (same four signals as s0, for source 1)
//  m_axis_data    out  DATA_WIDTH  to TX controller
//  m_axis_valid   out  1
//  m_axis_ready   in   1
//  m_axis_last    out  1
//  grant          out  1           source currently forwarded
//  err_count      out  ERR_WIDTH   saturating count of re-pairing events
// BEHAVIOUR
//  - Reset (async assert; deassert takes effect on the next axis_clk edge): m_axis_valid=0, m_axis_data=0,
//    m_axis_last=0, grant=0, state=EXP_LEFT, err_count=0, sync flops=0, s*_ready=0 during reset.
//  - sel and mute pass through 2-flop synchronizers; sel_s/mute_s are the synchronized values.
//  - Output register: one stage, 1-cycle latency from source handshake to m_axis_valid.
//    Granted source ready = !m_axis_valid || m_axis_ready (full throughput, no bubble).
//  - Non-granted source: ready = DRAIN_UNSEL. Its data never reaches m_axis.
//  - FSM (state advances only on an accepted granted beat):
//    EXP_LEFT, beat last=0  -> forward with last=0; go to EXP_RIGHT.
//    EXP_LEFT, beat last=1  -> orphan right: drop (no m_axis beat), err++, stay in EXP_LEFT.
//    EXP_RIGHT, beat last=1 -> forward with last=1; go to EXP_LEFT.
//    EXP_RIGHT, beat last=0 -> forward with last forced to 1 (re-pair), err++, go to EXP_LEFT.
//  - Grant update: grant<=sel_s only in a cycle where state=EXP_LEFT and no granted beat is accepted.
//    A sel change mid-frame waits until the right beat completes. Output is never a left/right mix of sources.
//  - Mute: m_axis_data<=0 for beats accepted while mute_s=1. Handshakes and last are unaffected.
//    Sampled per beat, so a frame may be half-muted.
//  - Backpressure: m_axis_data, m_axis_last and m_axis_valid are held stable while valid && !ready.
//  - err_count saturates at all-ones; it does not wrap.
//  - Simultaneous accept on both sources (DRAIN_UNSEL=1): only the granted source's beat is used.
// STRUCTURE
//  - Package axis_audio_pkg: DATA_WIDTH default; chan_t enum {EXP_LEFT, EXP_RIGHT}; LAST_RIGHT=1'b1.
//  - Sub-module axis_reg_slice: single-entry AXIS output register (data+last, valid/ready).
//  - Top level holds the synchronizers, FSM, grant logic, mute mux and error counter.
// TESTING
//  1 reset mid-frame: assert reset after left beat accepted -> m_axis_valid=0, err_count=0,
//    grant=0 in the same cycle; the next s0 left beat after release is forwarded.
//  2 passthrough: s0 frames {L=24'h000123,last=0},{R=24'hABCDEF,last=1}, m_ready=1 -> identical on m_axis
//    1 cycle later, back-to-back at full rate, s1 drained, grant=0.
//  3 switch: toggle sel between s0 L and R -> s0 R still forwarded, next frame from s1,
//    grant changes 3 cycles after the sel edge at the earliest and only in EXP_LEFT.
//  4 orphan/repair: s0 sends R(last=1) in EXP_LEFT -> dropped, err_count=1; then L,L ->
//    second L emitted with last=1, err_count=2.
//  5 backpressure+mute: m_ready toggles 1010, mute=1 -> data=0, last pattern 0,1 kept,
//    outputs stable while stalled, no beat lost or duplicated.
//  6 saturation: ERR_WIDTH=2, 5 orphan beats -> err_count=3.

Source files
------------

// File: rtl/axis_audio_pkg.sv
// Shared types and constants for the AXIS stereo audio path.
// A frame is a left beat followed by a right beat; last=1 marks the right channel.
package axis_audio_pkg;

  localparam int DATA_WIDTH = 24;

  typedef enum logic {
    EXP_LEFT  = 1'b0,
    EXP_RIGHT = 1'b1
  } chan_t;

  localparam logic LAST_RIGHT = 1'b1;

endpackage

// File: rtl/axis_reg_slice.sv
// Single-entry AXIS output register carrying data and last.
// A new beat may load in the same cycle that the held beat is consumed, so there is no bubble.
module axis_reg_slice #(
  parameter int DATA_WIDTH = 24
) (
  input  logic                  axis_clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_last,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic                  out_valid,
  input  logic                  out_ready
);

  assign in_ready = !out_valid || out_ready;

  always_ff @(posedge axis_clk or posedge reset) begin
    if (reset) begin
      out_data  <= '0;
      out_last  <= 1'b0;
      out_valid <= 1'b0;
    end else if (in_valid && in_ready) begin
      out_data  <= in_data;
      out_last  <= in_last;
      out_valid <= 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/axis_stereo_source_arbiter.sv
// Two-source AXIS arbiter for the I2S2 TX stream: switches sources only between frames,
// re-pairs broken left/right framing, counts those events and optionally mutes the data.
module axis_stereo_source_arbiter
  import axis_audio_pkg::*;
#(
  parameter int DATA_WIDTH  = axis_audio_pkg::DATA_WIDTH,
  parameter int DRAIN_UNSEL = 1,
  parameter int ERR_WIDTH   = 8
) (
  input  logic                  axis_clk,
  input  logic                  reset,
  input  logic                  sel,
  input  logic                  mute,
  input  logic [DATA_WIDTH-1:0] s0_axis_data,
  input  logic                  s0_axis_valid,
  output logic                  s0_axis_ready,
  input  logic                  s0_axis_last,
  input  logic [DATA_WIDTH-1:0] s1_axis_data,
  input  logic                  s1_axis_valid,
  output logic                  s1_axis_ready,
  input  logic                  s1_axis_last,
  output logic [DATA_WIDTH-1:0] m_axis_data,
  output logic                  m_axis_valid,
  input  logic                  m_axis_ready,
  output logic                  m_axis_last,
  output logic                  grant,
  output logic [ERR_WIDTH-1:0]  err_count
);

  localparam logic DRAIN = (DRAIN_UNSEL != 0);

  logic                  sel_meta, sel_s, mute_meta, mute_s;
  chan_t                 state, state_next;
  logic [DATA_WIDTH-1:0] g_data, push_data;
  logic                  g_valid, g_last, slice_ready, accept;
  logic                  push, push_last, err_inc;

  // sel and mute are free-running switch inputs, so both go through two flops
  always_ff @(posedge axis_clk or posedge reset) begin
    if (reset) begin
      sel_meta  <= 1'b0;
      sel_s     <= 1'b0;
      mute_meta <= 1'b0;
      mute_s    <= 1'b0;
    end else begin
      sel_meta  <= sel;
      sel_s     <= sel_meta;
      mute_meta <= mute;
      mute_s    <= mute_meta;
    end
  end

  assign g_data  = grant ? s1_axis_data  : s0_axis_data;
  assign g_valid = grant ? s1_axis_valid : s0_axis_valid;
  assign g_last  = grant ? s1_axis_last  : s0_axis_last;
  assign accept  = g_valid && slice_ready;

  assign s0_axis_ready = !reset && (grant ? DRAIN : slice_ready);
  assign s1_axis_ready = !reset && (grant ? slice_ready : DRAIN);

  always_ff @(posedge axis_clk or posedge reset) begin
    if (reset) state <= EXP_LEFT;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (accept) begin
      case (state)
        EXP_LEFT:  if (g_last != LAST_RIGHT) state_next = EXP_RIGHT;
        EXP_RIGHT: state_next = EXP_LEFT;
        default:   state_next = EXP_LEFT;
      endcase
    end
  end

  // An orphan right beat is swallowed; a second left beat closes the frame as a right beat
  always_comb begin
    push      = 1'b0;
    push_last = 1'b0;
    err_inc   = 1'b0;
    if (accept) begin
      case (state)
        EXP_LEFT: begin
          if (g_last == LAST_RIGHT) err_inc = 1'b1;
          else                      push    = 1'b1;
        end
        EXP_RIGHT: begin
          push      = 1'b1;
          push_last = LAST_RIGHT;
          err_inc   = (g_last != LAST_RIGHT);
        end
        default: ;
      endcase
    end
  end

  // Switching only between frames keeps a frame from mixing two producers
  always_ff @(posedge axis_clk or posedge reset) begin
    if (reset)                             grant <= 1'b0;
    else if (state == EXP_LEFT && !accept) grant <= sel_s;
  end

  always_ff @(posedge axis_clk or posedge reset) begin
    if (reset)                             err_count <= '0;
    else if (err_inc && err_count != '1)   err_count <= err_count + ERR_WIDTH'(1);
  end

  assign push_data = mute_s ? '0 : g_data;

  axis_reg_slice #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_out_slice (
    .axis_clk (axis_clk),
    .reset    (reset),
    .in_data  (push_data),
    .in_last  (push_last),
    .in_valid (push),
    .in_ready (slice_ready),
    .out_data (m_axis_data),
    .out_last (m_axis_last),
    .out_valid(m_axis_valid),
    .out_ready(m_axis_ready)
  );

endmodule
